// File: rtl/adder_seq_pkg.sv
// Shared definitions for the adder AXI4-Lite sequencer: FSM encodings,
// default adder register map and AXI response codes.
package adder_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_A,
    WB_A,
    WR_B,
    WB_B,
    AR_SUM,
    R_SUM,
    AR_AUX,
    R_AUX,
    RESP
  } seq_state_t;

  typedef enum logic [2:0] {
    X_IDLE,
    X_AW_W,
    X_B,
    X_AR,
    X_R
  } xfer_state_t;

  localparam logic [7:0] DEF_OPA_ADDR = 8'h00;
  localparam logic [7:0] DEF_OPB_ADDR = 8'h04;
  localparam logic [7:0] DEF_SUM_ADDR = 8'h08;
  localparam logic [7:0] DEF_AUX_ADDR = 8'h0C;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // States in which an AXI transfer is outstanding.
  function automatic logic is_axi_state(input seq_state_t s);
    return (s != IDLE) && (s != RESP);
  endfunction

endpackage

// File: rtl/adder_axil_xfer.sv
// Single-beat AXI4-Lite write/read engine. A new transfer may be started in
// the same cycle the previous one completes, so back-to-back beats add no bubble.
module adder_axil_xfer
  import adder_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic                    start,
  input  logic                    rnw,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    abort,
  output logic                    addr_done,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic                    m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  xfer_state_t xs_reg;
  logic        aw_ok;
  logic        w_ok;

  // A channel is complete once its valid has dropped or handshakes this edge.
  assign aw_ok        = !m1_axi_awvalid || m1_axi_awready;
  assign w_ok         = !m1_axi_wvalid || m1_axi_wready;
  assign rdata        = m1_axi_rdata;
  assign m1_axi_wstrb = '1;

  always_comb begin
    addr_done = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (xs_reg)
      X_AW_W: addr_done = aw_ok && w_ok;
      X_AR:   addr_done = m1_axi_arready;
      X_B: begin
        done = m1_axi_bvalid;
        err  = (m1_axi_bresp != RESP_OKAY);
      end
      X_R: begin
        done = m1_axi_rvalid;
        err  = (m1_axi_rresp == RESP_ERR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge m1_axi_aclk) begin
    if (!m1_axi_aresetn) begin
      xs_reg         <= X_IDLE;
      m1_axi_awaddr  <= '0;
      m1_axi_awvalid <= 1'b0;
      m1_axi_wdata   <= '0;
      m1_axi_wvalid  <= 1'b0;
      m1_axi_bready  <= 1'b0;
      m1_axi_araddr  <= '0;
      m1_axi_arvalid <= 1'b0;
      m1_axi_rready  <= 1'b0;
    end else begin
      case (xs_reg)
        X_AW_W: begin
          if (m1_axi_awready) m1_axi_awvalid <= 1'b0;
          if (m1_axi_wready)  m1_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m1_axi_bready <= 1'b1;
            xs_reg        <= X_B;
          end
        end
        X_B: begin
          if (m1_axi_bvalid) begin
            m1_axi_bready <= 1'b0;
            xs_reg        <= X_IDLE;
          end
        end
        X_AR: begin
          if (m1_axi_arready) begin
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b1;
            xs_reg         <= X_R;
          end
        end
        X_R: begin
          if (m1_axi_rvalid) begin
            m1_axi_rready <= 1'b0;
            xs_reg        <= X_IDLE;
          end
        end
        default: ;
      endcase

      if (start && ((xs_reg == X_IDLE) || done)) begin
        if (rnw) begin
          m1_axi_araddr  <= addr;
          m1_axi_arvalid <= 1'b1;
          xs_reg         <= X_AR;
        end else begin
          m1_axi_awaddr  <= addr;
          m1_axi_wdata   <= wdata;
          m1_axi_awvalid <= 1'b1;
          m1_axi_wvalid  <= 1'b1;
          xs_reg         <= X_AW_W;
        end
      end

      if (abort) begin
        m1_axi_awvalid <= 1'b0;
        m1_axi_wvalid  <= 1'b0;
        m1_axi_bready  <= 1'b0;
        m1_axi_arvalid <= 1'b0;
        m1_axi_rready  <= 1'b0;
        xs_reg         <= X_IDLE;
      end
    end
  end

endmodule

// File: rtl/adder_axi_sequencer.sv
// AXI4-Lite master: writes operands A/B to the adder, reads sum and aux back.
// Define ADDER_SEQ_TIMEOUT_EN to add a per-state watchdog (TIMEOUT_CYCLES).
module adder_axi_sequencer
  import adder_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] OPA_ADDR   = ADDR_WIDTH'(DEF_OPA_ADDR),
  parameter logic [ADDR_WIDTH-1:0] OPB_ADDR   = ADDR_WIDTH'(DEF_OPB_ADDR),
  parameter logic [ADDR_WIDTH-1:0] SUM_ADDR   = ADDR_WIDTH'(DEF_SUM_ADDR),
  parameter logic [ADDR_WIDTH-1:0] AUX_ADDR   = ADDR_WIDTH'(DEF_AUX_ADDR)
`ifdef ADDER_SEQ_TIMEOUT_EN
  , parameter int                  TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_sum,
  output logic [DATA_WIDTH-1:0]   rsp_aux,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic                    m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  seq_state_t              state_reg;
  logic [DATA_WIDTH-1:0]   op_b_reg;
  logic                    x_start;
  logic                    x_rnw;
  logic [ADDR_WIDTH-1:0]   x_addr;
  logic [DATA_WIDTH-1:0]   x_wdata;
  logic                    x_addr_done;
  logic                    x_done;
  logic [DATA_WIDTH-1:0]   x_rdata;
  logic                    x_err;
  logic                    timeout;

  // Next transfer is launched on the edge the previous one finishes.
  // Operand A goes straight from the command port into the write engine.
  always_comb begin
    x_start = 1'b0;
    x_rnw   = 1'b0;
    x_addr  = OPA_ADDR;
    x_wdata = cmd_a;
    case (state_reg)
      IDLE:  x_start = cmd_valid && cmd_ready;
      WB_A: begin
        x_start = x_done;
        x_addr  = OPB_ADDR;
        x_wdata = op_b_reg;
      end
      WB_B: begin
        x_start = x_done;
        x_rnw   = 1'b1;
        x_addr  = SUM_ADDR;
      end
      R_SUM: begin
        x_start = x_done;
        x_rnw   = 1'b1;
        x_addr  = AUX_ADDR;
      end
      default: ;
    endcase
  end

  adder_axil_xfer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_xfer (
    .m1_axi_aclk    (m1_axi_aclk),
    .m1_axi_aresetn (m1_axi_aresetn),
    .start          (x_start),
    .rnw            (x_rnw),
    .addr           (x_addr),
    .wdata          (x_wdata),
    .abort          (timeout),
    .addr_done      (x_addr_done),
    .done           (x_done),
    .rdata          (x_rdata),
    .err            (x_err),
    .m1_axi_awaddr  (m1_axi_awaddr),
    .m1_axi_awvalid (m1_axi_awvalid),
    .m1_axi_awready (m1_axi_awready),
    .m1_axi_wdata   (m1_axi_wdata),
    .m1_axi_wstrb   (m1_axi_wstrb),
    .m1_axi_wvalid  (m1_axi_wvalid),
    .m1_axi_wready  (m1_axi_wready),
    .m1_axi_bresp   (m1_axi_bresp),
    .m1_axi_bvalid  (m1_axi_bvalid),
    .m1_axi_bready  (m1_axi_bready),
    .m1_axi_araddr  (m1_axi_araddr),
    .m1_axi_arvalid (m1_axi_arvalid),
    .m1_axi_arready (m1_axi_arready),
    .m1_axi_rdata   (m1_axi_rdata),
    .m1_axi_rresp   (m1_axi_rresp),
    .m1_axi_rvalid  (m1_axi_rvalid),
    .m1_axi_rready  (m1_axi_rready)
  );

`ifdef ADDER_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t      prev_state_reg;
  logic [TO_W-1:0] dwell_reg;
  logic [TO_W-1:0] dwell;

  // Cycles already spent in the current state; restarts on any state change.
  assign dwell   = (state_reg != prev_state_reg) ? '0 : dwell_reg;
  assign timeout = is_axi_state(state_reg) && (dwell == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge m1_axi_aclk) begin
    if (!m1_axi_aresetn) begin
      prev_state_reg <= IDLE;
      dwell_reg      <= '0;
    end else begin
      prev_state_reg <= state_reg;
      dwell_reg      <= is_axi_state(state_reg) ? dwell + 1'b1 : '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge m1_axi_aclk) begin
    if (!m1_axi_aresetn) begin
      state_reg <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_aux   <= '0;
      rsp_err   <= 1'b0;
      op_b_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_b_reg  <= cmd_b;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state_reg <= WR_A;
          end
        end
        WR_A:   if (x_addr_done) state_reg <= WB_A;
        WB_A: begin
          if (x_done) begin
            rsp_err   <= rsp_err | x_err;
            state_reg <= WR_B;
          end
        end
        WR_B:   if (x_addr_done) state_reg <= WB_B;
        WB_B: begin
          if (x_done) begin
            rsp_err   <= rsp_err | x_err;
            state_reg <= AR_SUM;
          end
        end
        AR_SUM: if (x_addr_done) state_reg <= R_SUM;
        R_SUM: begin
          if (x_done) begin
            rsp_sum   <= x_rdata;
            rsp_err   <= rsp_err | x_err;
            state_reg <= AR_AUX;
          end
        end
        AR_AUX: if (x_addr_done) state_reg <= R_AUX;
        R_AUX: begin
          if (x_done) begin
            rsp_aux   <= x_rdata;
            rsp_err   <= rsp_err | x_err;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (timeout) begin
        rsp_sum   <= '0;
        rsp_aux   <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= 1'b1;
        state_reg <= RESP;
      end
    end
  end

endmodule

// File: tb/tb_adder_axi_sequencer.sv
// Scoreboard bench for adder_axi_sequencer against a behavioural adder slave
// (sum = A + B, aux = A ^ B) with a programmable awready delay and bresp error.
module tb_adder_axi_sequencer;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          m1_axi_aclk    = 1'b0;
  logic          m1_axi_aresetn = 1'b0;
  logic          cmd_valid      = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a          = '0;
  logic [DW-1:0] cmd_b          = '0;
  logic          rsp_valid;
  logic          rsp_ready      = 1'b0;
  logic [DW-1:0] rsp_sum;
  logic [DW-1:0] rsp_aux;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] m1_axi_awaddr;
  logic          m1_axi_awvalid;
  logic          m1_axi_awready;
  logic [DW-1:0] m1_axi_wdata;
  logic [DW/8-1:0] m1_axi_wstrb;
  logic          m1_axi_wvalid;
  logic          m1_axi_wready;
  logic          m1_axi_bresp;
  logic          m1_axi_bvalid;
  logic          m1_axi_bready;
  logic [AW-1:0] m1_axi_araddr;
  logic          m1_axi_arvalid;
  logic          m1_axi_arready;
  logic [DW-1:0] m1_axi_rdata;
  logic          m1_axi_rresp;
  logic          m1_axi_rvalid;
  logic          m1_axi_rready;

  adder_axi_sequencer dut (
    .m1_axi_aclk    (m1_axi_aclk),
    .m1_axi_aresetn (m1_axi_aresetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_sum        (rsp_sum),
    .rsp_aux        (rsp_aux),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .m1_axi_awaddr  (m1_axi_awaddr),
    .m1_axi_awvalid (m1_axi_awvalid),
    .m1_axi_awready (m1_axi_awready),
    .m1_axi_wdata   (m1_axi_wdata),
    .m1_axi_wstrb   (m1_axi_wstrb),
    .m1_axi_wvalid  (m1_axi_wvalid),
    .m1_axi_wready  (m1_axi_wready),
    .m1_axi_bresp   (m1_axi_bresp),
    .m1_axi_bvalid  (m1_axi_bvalid),
    .m1_axi_bready  (m1_axi_bready),
    .m1_axi_araddr  (m1_axi_araddr),
    .m1_axi_arvalid (m1_axi_arvalid),
    .m1_axi_arready (m1_axi_arready),
    .m1_axi_rdata   (m1_axi_rdata),
    .m1_axi_rresp   (m1_axi_rresp),
    .m1_axi_rvalid  (m1_axi_rvalid),
    .m1_axi_rready  (m1_axi_rready)
  );

  always #5 m1_axi_aclk = ~m1_axi_aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge m1_axi_aclk) cyc <= cyc + 1;

  // ---------------- behavioural adder slave ----------------
  int            aw_hold  = 0;
  int            aw_delay = 0;
  bit            err_on_b = 1'b0;
  int            wr_cnt   = 0;
  int            rd_cnt   = 0;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  logic [DW-1:0] s_opa, s_opb;
  logic          aw_f, w_f, wr_go;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  assign m1_axi_awready = (aw_hold + 1 >= aw_delay);
  assign m1_axi_wready  = 1'b1;
  assign m1_axi_arready = 1'b1;
  assign aw_f  = m1_axi_awvalid && m1_axi_awready;
  assign w_f   = m1_axi_wvalid && m1_axi_wready;
  assign wr_go = (aw_got || aw_f) && (w_got || w_f);
  assign wa    = aw_got ? aw_a : m1_axi_awaddr;
  assign wd    = w_got ? w_d : m1_axi_wdata;

  always @(posedge m1_axi_aclk) begin
    if (!m1_axi_aresetn) begin
      aw_hold <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      m1_axi_bvalid <= 1'b0; m1_axi_bresp <= 1'b0;
      m1_axi_rvalid <= 1'b0; m1_axi_rresp <= 1'b0; m1_axi_rdata <= '0;
      s_opa <= '0; s_opb <= '0;
    end else begin
      aw_hold <= (m1_axi_awvalid && !m1_axi_awready) ? aw_hold + 1 : 0;
      if (m1_axi_bvalid && m1_axi_bready) m1_axi_bvalid <= 1'b0;
      if (m1_axi_rvalid && m1_axi_rready) m1_axi_rvalid <= 1'b0;
      if (wr_go) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        m1_axi_bvalid <= 1'b1;
        m1_axi_bresp  <= (wa == 8'h04) && err_on_b;
        wr_cnt <= wr_cnt + 1;
        if (wa == 8'h00) s_opa <= wd;
        else if (wa == 8'h04) s_opb <= wd;
      end else begin
        if (aw_f) begin aw_got <= 1'b1; aw_a <= m1_axi_awaddr; end
        if (w_f)  begin w_got  <= 1'b1; w_d  <= m1_axi_wdata;  end
      end
      if (m1_axi_arvalid && m1_axi_arready) begin
        m1_axi_rvalid <= 1'b1;
        m1_axi_rresp  <= 1'b0;
        rd_cnt <= rd_cnt + 1;
        case (m1_axi_araddr)
          8'h00:   m1_axi_rdata <= s_opa;
          8'h04:   m1_axi_rdata <= s_opb;
          8'h08:   m1_axi_rdata <= s_opa + s_opb;
          8'h0C:   m1_axi_rdata <= s_opa ^ s_opb;
          default: m1_axi_rdata <= '0;
        endcase
      end
    end
  end

  // ---------------- AW/W valid-length and stability monitor ----------------
  int            aw_len = 0, w_len = 0, last_aw_len = 0, last_w_len = 0;
  logic [AW-1:0] aw_first;
  logic [DW-1:0] w_first;

  always @(negedge m1_axi_aclk) begin
    if (!m1_axi_aresetn) begin
      aw_len <= 0;
      w_len  <= 0;
    end else begin
      if (m1_axi_awvalid) begin
        if (aw_len == 0) aw_first <= m1_axi_awaddr;
        else chk("aw_stable", 64'(m1_axi_awaddr), 64'(aw_first));
        if (m1_axi_awready) begin last_aw_len <= aw_len + 1; aw_len <= 0; end
        else aw_len <= aw_len + 1;
      end
      if (m1_axi_wvalid) begin
        if (w_len == 0) w_first <= m1_axi_wdata;
        else chk("w_stable", 64'(m1_axi_wdata), 64'(w_first));
        if (m1_axi_wready) begin last_w_len <= w_len + 1; w_len <= 0; end
        else w_len <= w_len + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sum;
    logic [DW-1:0] aux;
    logic          err;
  } exp_t;

  exp_t sb[$];

  task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input int aw_dly,
                         input bit b_err, input int hold, input bit chk_lat);
    exp_t e;
    int   t_acc;
    int   wr0;
    int   rd0;
    e.a = a; e.b = b; e.sum = a + b; e.aux = a ^ b; e.err = b_err;
    @(negedge m1_axi_aclk);
    aw_delay = aw_dly;
    err_on_b = b_err;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    sb.push_back(e);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int n = 0; n < 50 && !cmd_ready; n++) @(negedge m1_axi_aclk);
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    t_acc = cyc + 1;
    @(negedge m1_axi_aclk);
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
    chk("busy_after_acc", 64'(busy), 64'(1));
    for (int n = 0; n < 300 && !rsp_valid; n++) @(negedge m1_axi_aclk);
    chk("rsp_valid_wait", 64'(rsp_valid), 64'(1));
    if (chk_lat) chk("latency", 64'(cyc + 1 - t_acc), 64'(9));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_sum", 64'(rsp_sum), 64'(sb[0].sum));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      @(negedge m1_axi_aclk);
    end
    rsp_ready = 1'b1;
    chk("no_cmd_overlap", 64'(cmd_ready), 64'(0));
    e = sb.pop_front();
    chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
    chk("rsp_aux", 64'(rsp_aux), 64'(e.aux));
    chk("rsp_err", 64'(rsp_err), 64'(e.err));
    $display("txn a=%0h b=%0h sum=%0h aux=%0h err=%0d (expect %0h/%0h/%0d)",
             e.a, e.b, rsp_sum, rsp_aux, rsp_err, e.sum, e.aux, e.err);
    @(negedge m1_axi_aclk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    chk("cmd_ready_back", 64'(cmd_ready), 64'(1));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("slave_opa", 64'(s_opa), 64'(e.a));
    chk("slave_opb", 64'(s_opb), 64'(e.b));
    chk("writes", 64'(wr_cnt - wr0), 64'(2));
    chk("reads", 64'(rd_cnt - rd0), 64'(2));
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    chk({pfx, "_busy"}, 64'(busy), 64'(0));
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({pfx, "_awvalid"}, 64'(m1_axi_awvalid), 64'(0));
    chk({pfx, "_wvalid"}, 64'(m1_axi_wvalid), 64'(0));
    chk({pfx, "_bready"}, 64'(m1_axi_bready), 64'(0));
    chk({pfx, "_arvalid"}, 64'(m1_axi_arvalid), 64'(0));
    chk({pfx, "_rready"}, 64'(m1_axi_rready), 64'(0));
    chk({pfx, "_awaddr"}, 64'(m1_axi_awaddr), 64'(0));
    chk({pfx, "_araddr"}, 64'(m1_axi_araddr), 64'(0));
    chk({pfx, "_wdata"}, 64'(m1_axi_wdata), 64'(0));
    chk({pfx, "_wstrb"}, 64'(m1_axi_wstrb), 64'(4'hF));
    chk({pfx, "_rsp_sum"}, 64'(rsp_sum), 64'(0));
    chk({pfx, "_rsp_aux"}, 64'(rsp_aux), 64'(0));
    chk({pfx, "_rsp_err"}, 64'(rsp_err), 64'(0));
  endtask

  initial begin
    repeat (3) @(negedge m1_axi_aclk);
    chk_idle_outputs("rst");
    m1_axi_aresetn = 1'b1;

    run_txn(32'd23, 32'd30, 0, 1'b0, 0, 1'b1);
    chk("aw_len_zero_wait", 64'(last_aw_len), 64'(1));
    chk("w_len_zero_wait", 64'(last_w_len), 64'(1));

    run_txn(32'h0000_1234, 32'h0000_4321, 3, 1'b0, 0, 1'b0);
    chk("aw_len_delayed", 64'(last_aw_len), 64'(3));
    chk("w_len_delayed", 64'(last_w_len), 64'(1));

    run_txn(32'd5, 32'd9, 0, 1'b1, 0, 1'b0);
    run_txn(32'd100, 32'd1, 0, 1'b0, 5, 1'b0);
    run_txn(32'hFFFF_FFFF, 32'd1, 0, 1'b0, 0, 1'b1);

    for (int i = 0; i < 4; i++)
      run_txn($urandom, $urandom, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'b0);

    // reset while the sum read address is being presented
    @(negedge m1_axi_aclk);
    aw_delay = 0;
    err_on_b = 1'b0;
    cmd_a = 32'd100; cmd_b = 32'd200; cmd_valid = 1'b1;
    for (int n = 0; n < 50 && !cmd_ready; n++) @(negedge m1_axi_aclk);
    @(negedge m1_axi_aclk);
    cmd_valid = 1'b0;
    for (int n = 0; n < 50 && !m1_axi_arvalid; n++) @(negedge m1_axi_aclk);
    chk("ar_sum_seen", 64'(m1_axi_arvalid), 64'(1));
    chk("ar_sum_addr", 64'(m1_axi_araddr), 64'(8'h08));
    m1_axi_aresetn = 1'b0;
    @(negedge m1_axi_aclk);
    chk_idle_outputs("midrst");
    m1_axi_aresetn = 1'b1;

    run_txn(32'd7, 32'd7, 0, 1'b0, 0, 1'b1);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
